warp_dispatch: RTL and testbench
================================

# warp_dispatch

Instruction issue stage sitting directly upstream of the per-thread functional units. It buffers 32-bit instruction words in a small FIFO, decodes them into opcode/register fields, and broadcasts one instruction per cycle to all functional units together with a per-thread active mask. After a HALT it waits for every active thread's `thread_complete`, then signals kernel completion.

## Interface
- `NUM_THREADS`, default 8: number of functional units driven; width of the mask and completion vectors.
- `DEPTH`, default 8: instruction FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_in` in 32: instruction word.
- `instr_valid` in 1: `instr_in` is valid.
- `instr_ready` out 1: FIFO not full; a push occurs when `instr_valid && instr_ready`.
- `start` in 1: launch pulse; sampled only in IDLE.
- `thread_mask` in NUM_THREADS: threads participating; latched on accepted `start`.
- `thread_complete` in NUM_THREADS: completion flags from the functional units.
- `type_instruction` out 3, `regnum_1` out 5, `regnum_2` out 5, `dest_reg` out 5, `shammt` out 6: registered decoded fields.
- `is_active` out NUM_THREADS: per-thread issue enable.
- `busy` out 1: state is not IDLE.
- `kernel_done` out 1: one-cycle pulse on drain completion.
- `issue_count` out 16, `bubble_count` out 16: performance counters (see Configuration).

## Operation
- Instruction format: [2:0] opcode, [7:3] rs1, [12:8] rs2, [17:13] rd, [23:18] shammt, [31:24] reserved, ignored.
- Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 FADD, 101 FSUB, 110 LOAD-regfile, 111 HALT. All opcodes are passed through unchanged; only HALT is interpreted here.
- FIFO accepts pushes in every state, including IDLE, so a kernel can be preloaded. There is no bypass: a word pushed into an empty FIFO is poppable on the next cycle. Pushes are ignored when full because `instr_ready` = 0.
- States:
  - IDLE: on `start`, if `thread_mask` ≠ 0, latch the mask and go to ISSUE. If `thread_mask` = 0, pulse `kernel_done` the next cycle and stay in IDLE; no pops occur.
  - ISSUE, FIFO non-empty: pop one word per cycle, register its fields, and drive `is_active` = latched mask. If the popped opcode is 111, go to DRAIN.
  - ISSUE, FIFO empty: issue a bubble with all fields 0 and `is_active` = 0, so the functional units do not write their register files.
  - DRAIN: fields 0, `is_active` = 0. When `&(thread_complete | ~mask)`, go to IDLE and assert `kernel_done` for one cycle.
- `start` is ignored outside IDLE.
- Words queued behind a HALT remain in the FIFO for the next kernel.

## Timing
- Reset: FIFO empty, state IDLE, every output 0 except `instr_ready` = 1; counters cleared.
- Issue latency: a word popped at edge E is presented on the outputs from E until the next edge, where the functional units capture it. Throughput is one instruction per cycle.
- HALT popped at edge E0 enters DRAIN at E0. The first completion check is the cycle after E1, so stale `thread_complete` values from bubbles cannot end the drain early.
- `kernel_done` is high for exactly one cycle, coincident with `busy` falling.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- Pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.
- Reset mid-kernel: asynchronous return to the reset values above; queued words are lost.

## Configuration
- `WARP_DISPATCH_PERF_EN` defined:
  - `issue_count` increments on every non-bubble issue, HALT included.
  - `bubble_count` increments on every ISSUE-state bubble.
  - Both saturate at 16'hFFFF and clear on accepted `start` and on `rst`.
- Not defined: both counters are tied to 0 and no counter logic is built.

## Test plan
- Preload ADD(rs1=1, rs2=2, rd=3), SUB, HALT in IDLE; `start`, mask 8'h0F → three consecutive issue cycles with `is_active` = 8'h0F and correct fields; `kernel_done` one cycle after all four low threads' `thread_complete` = 1.
- `start` with empty FIFO, then push HALT 3 cycles later → 3 bubbles with `is_active` = 0; `bubble_count` = 3 (macro on).
- Push DEPTH+2 words with no start → `instr_ready` drops after DEPTH accepts; the last 2 words are never stored.
- HALT issued, then hold `thread_complete[2]` low for 5 cycles with mask 8'h07 → `busy` stays 1 until bit 2 rises; `kernel_done` then pulses once.
- `start` with mask 0 → `kernel_done` the next cycle, FIFO contents untouched.
- Assert `rst` during ISSUE → all outputs return to reset values immediately; FIFO empty; a subsequent kernel runs normally.

Source files
------------

// File: rtl/warp_dispatch.sv
// rtl/warp_dispatch.sv - instruction FIFO, decode and broadcast issue stage with HALT drain
// Optional performance counters: define WARP_DISPATCH_PERF_EN.
module warp_dispatch #(
    parameter int NUM_THREADS = 8,
    parameter int DEPTH       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            instr_in,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic                   start,
    input  logic [NUM_THREADS-1:0] thread_mask,
    input  logic [NUM_THREADS-1:0] thread_complete,
    output logic [2:0]             type_instruction,
    output logic [4:0]             regnum_1,
    output logic [4:0]             regnum_2,
    output logic [4:0]             dest_reg,
    output logic [5:0]             shammt,
    output logic [NUM_THREADS-1:0] is_active,
    output logic                   busy,
    output logic                   kernel_done,
    output logic [15:0]            issue_count,
    output logic [15:0]            bubble_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                 state_q;
    logic [23:0]            mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [NUM_THREADS-1:0] mask_q;
    logic                   drain_armed_q;
    logic                   empty, full, push, pop;
    logic [23:0]            head;
    logic                   unused_reserved;

    // Reserved bits [31:24] are never stored.
    assign unused_reserved = ^instr_in[31:24];

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign instr_ready = ~full;
    assign push        = instr_valid && ~full;
    assign pop         = (state_q == S_ISSUE) && ~empty;
    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign busy        = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= instr_in[23:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            mask_q           <= '0;
            drain_armed_q    <= 1'b0;
            type_instruction <= '0;
            regnum_1         <= '0;
            regnum_2         <= '0;
            dest_reg         <= '0;
            shammt           <= '0;
            is_active        <= '0;
            kernel_done      <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            type_instruction <= '0;
            regnum_1         <= '0;
            regnum_2         <= '0;
            dest_reg         <= '0;
            shammt           <= '0;
            is_active        <= '0;
            kernel_done      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (|thread_mask) begin
                            mask_q  <= thread_mask;
                            state_q <= S_ISSUE;
                        end else begin
                            kernel_done <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!empty) begin
                        type_instruction <= head[2:0];
                        regnum_1         <= head[7:3];
                        regnum_2         <= head[12:8];
                        dest_reg         <= head[17:13];
                        shammt           <= head[23:18];
                        is_active        <= mask_q;
                        if (head[2:0] == 3'b111) begin
                            state_q       <= S_DRAIN;
                            drain_armed_q <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Skip the first drain cycle so completion flags left over from bubbles are ignored.
                    if (!drain_armed_q) begin
                        drain_armed_q <= 1'b1;
                    end else if (&(thread_complete | ~mask_q)) begin
                        state_q     <= S_IDLE;
                        kernel_done <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef WARP_DISPATCH_PERF_EN
    logic [15:0] issue_cnt_q, bubble_cnt_q;
    logic        cnt_clear;

    assign cnt_clear = (state_q == S_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (cnt_clear) begin
            issue_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            if (!empty && issue_cnt_q != 16'hFFFF) begin
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            if (empty && bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
        end
    end

    assign issue_count  = issue_cnt_q;
    assign bubble_count = bubble_cnt_q;
`else
    assign issue_count  = 16'd0;
    assign bubble_count = 16'd0;
`endif

endmodule

// File: tb/tb_warp_dispatch.sv
// tb/tb_warp_dispatch.sv - self-checking bench for warp_dispatch with a queue-based reference model
module tb_warp_dispatch;
    localparam int NT = 8;
    localparam int D  = 8;
`ifdef WARP_DISPATCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr_in = '0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic          start = 1'b0;
    logic [NT-1:0] thread_mask = '0;
    logic [NT-1:0] thread_complete = '0;
    logic [2:0]    type_instruction;
    logic [4:0]    regnum_1, regnum_2, dest_reg;
    logic [5:0]    shammt;
    logic [NT-1:0] is_active;
    logic          busy, kernel_done;
    logic [15:0]   issue_count, bubble_count;

    int n_checks = 0;
    int n_fail   = 0;

    warp_dispatch #(.NUM_THREADS(NT), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .start(start), .thread_mask(thread_mask),
        .thread_complete(thread_complete), .type_instruction(type_instruction),
        .regnum_1(regnum_1), .regnum_2(regnum_2), .dest_reg(dest_reg), .shammt(shammt),
        .is_active(is_active), .busy(busy), .kernel_done(kernel_done),
        .issue_count(issue_count), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending words, phase of the kernel, expected registered outputs.
    logic [31:0]   mq[$];
    int            m_phase = 0;      // 0 idle, 1 issuing, 2 draining
    int            m_drain_age = 0;
    logic [NT-1:0] m_mask = '0;
    logic [31:0]   m_word = '0;
    logic [NT-1:0] m_act = '0;
    logic          m_kd = 1'b0;
    logic [15:0]   m_ic = '0, m_bc = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_phase = 0; m_drain_age = 0; m_mask = '0;
            m_word = '0; m_act = '0; m_kd = 1'b0; m_ic = '0; m_bc = '0;
        end else begin
            logic        do_push;
            logic [31:0] w;
            do_push = instr_valid && (mq.size() < D);
            w = instr_in;
            m_word = '0; m_act = '0; m_kd = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    m_ic = '0; m_bc = '0;
                    if (thread_mask != '0) begin
                        m_mask = thread_mask; m_phase = 1;
                    end else m_kd = 1'b1;
                end
            end else if (m_phase == 1) begin
                if (mq.size() > 0) begin
                    m_word = mq.pop_front();
                    m_act = m_mask;
                    if (m_ic != 16'hFFFF) m_ic = m_ic + 1;
                    if (m_word[2:0] == 3'd7) begin
                        m_phase = 2; m_drain_age = 0;
                    end
                end else if (m_bc != 16'hFFFF) m_bc = m_bc + 1;
            end else begin
                m_drain_age++;
                if (m_drain_age >= 2 && (thread_complete | ~m_mask) == {NT{1'b1}}) begin
                    m_phase = 0; m_kd = 1'b1;
                end
            end
            if (do_push) mq.push_back(w);
        end
    end

    always @(negedge clk) begin
        chk("instr_ready", instr_ready, mq.size() < D);
        chk("busy", busy, m_phase != 0);
        chk("kernel_done", kernel_done, m_kd);
        chk("is_active", is_active, m_act);
        chk("type", type_instruction, m_word[2:0]);
        chk("rs1", regnum_1, m_word[7:3]);
        chk("rs2", regnum_2, m_word[12:8]);
        chk("rd", dest_reg, m_word[17:13]);
        chk("shammt", shammt, m_word[23:18]);
        chk("issue_count", issue_count, PERF ? m_ic : 16'd0);
        chk("bubble_count", bubble_count, PERF ? m_bc : 16'd0);
    end

    function automatic logic [31:0] mk(input int op, input int r1, input int r2, input int rd, input int sh);
        logic [31:0] w;
        w = 32'hA5000000;
        w[2:0] = op[2:0]; w[7:3] = r1[4:0]; w[12:8] = r2[4:0];
        w[17:13] = rd[4:0]; w[23:18] = sh[5:0];
        return w;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        instr_in = w; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic kick(input logic [NT-1:0] m);
        start = 1'b1; thread_mask = m;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        bit got;
        got = 0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (kernel_done) begin got = 1; break; end
        end
        chk(name, got, 1);
        chk({name, "_busy_low"}, busy, 0);
        tick();
        chk({name, "_one_cycle"}, kernel_done, 0);
    endtask

    initial begin
        tick();
        chk("reset_ready", instr_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_active", is_active, 0);
        rst = 1'b0;
        tick();

        // Preloaded kernel: ADD, SUB, HALT on four threads.
        push(mk(0, 1, 2, 3, 0));
        push(mk(1, 4, 5, 6, 7));
        push(mk(7, 0, 0, 0, 0));
        kick(8'h0F);
        tick();
        chk("add_type", type_instruction, 0);
        chk("add_rs1", regnum_1, 1);
        chk("add_rs2", regnum_2, 2);
        chk("add_rd", dest_reg, 3);
        chk("add_active", is_active, 8'h0F);
        tick();
        chk("sub_type", type_instruction, 1);
        chk("sub_shammt", shammt, 7);
        tick();
        chk("halt_type", type_instruction, 7);
        chk("halt_active", is_active, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_busy", busy, 1);
        end
        thread_complete = 8'h0F;
        wait_done("k1_done", 10);
        chk("k1_issue_count", issue_count, PERF ? 3 : 0);
        thread_complete = '0;

        // Start on an empty FIFO; HALT arrives late, giving three bubbles.
        thread_complete = 8'hFF;
        kick(8'hFF);
        tick();
        chk("bubble_active", is_active, 0);
        tick();
        push(mk(7, 0, 0, 0, 0));
        wait_done("k2_done", 10);
        chk("k2_bubbles", bubble_count, PERF ? 3 : 0);
        chk("k2_issues", issue_count, PERF ? 1 : 0);

        // Thread 2 holds the drain open.
        thread_complete = 8'b0000_0011;
        push(mk(7, 0, 0, 0, 0));
        kick(8'h07);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_busy", busy, 1);
        end
        thread_complete = 8'b0000_0111;
        wait_done("k3_done", 10);
        thread_complete = '0;

        // Overfill the FIFO while idle.
        for (int i = 0; i < D + 2; i++) begin
            instr_in = mk((i < D - 1) ? i : ((i == D - 1) ? 7 : 0), i + 1, i + 2, i + 3, i);
            instr_valid = 1'b1;
            tick();
        end
        instr_valid = 1'b0;
        chk("full_ready", instr_ready, 0);

        // Empty mask: immediate completion, FIFO untouched.
        kick(8'h00);
        chk("mask0_done", kernel_done, 1);
        chk("mask0_busy", busy, 0);
        chk("mask0_full", instr_ready, 0);
        tick();
        chk("mask0_pulse", kernel_done, 0);

        thread_complete = 8'h01;
        kick(8'h01);
        tick();
        chk("fill_first_rs1", regnum_1, 1);
        chk("fill_first_ready", instr_ready, 1);
        wait_done("k4_done", 20);
        thread_complete = '0;

        // Asynchronous reset in the middle of issuing.
        push(mk(0, 5, 6, 7, 1));
        push(mk(0, 5, 6, 7, 2));
        push(mk(0, 5, 6, 7, 3));
        kick(8'hFF);
        tick();
        chk("pre_rst_rs1", regnum_1, 5);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_active", is_active, 0);
        chk("rst_rs1", regnum_1, 0);
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", kernel_done, 0);
        tick();
        rst = 1'b0;
        tick();
        push(mk(0, 7, 8, 9, 0));
        push(mk(7, 0, 0, 0, 0));
        thread_complete = 8'hFF;
        kick(8'hFF);
        tick();
        chk("post_rst_rd", dest_reg, 9);
        chk("post_rst_active", is_active, 8'hFF);
        wait_done("k5_done", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
